coherence_bus_arbiter: RTL and testbench
========================================

// Module: coherence_bus_arbiter
// PURPOSE
//  Parametrised memory-bus controller between NCACHE icache/dcache pairs and one shared RAM port.
//  Generalises the 2-cache controller with:
//  - round-robin arbitration across any number of caches;
//  - multi-word block transfers sized by a parameter;
//  - snoop broadcast to all peer caches;
//  - cache-to-cache supply of dirty lines with concurrent RAM writeback.
//  Sits between the per-core caches and the memory controller.
// PARAMETERS
//  NCACHE  2   number of cache pairs (>=2)
//  WPB     2   words per block; beats per data-block transaction
//  AW      32  address width
//  DW      32  data width
// PORTS
//  CLK          in   1          clock, rising edge
//  RST          in   1          reset, asynchronous, active-high
//  iREN         in   NCACHE     icache read request
//  iaddr        in   NCACHE*AW  icache address, packed: cache k at [k*AW +: AW]
//  iwait        out  NCACHE     icache stall
//  iload        out  NCACHE*DW  icache read data
//  dREN         in   NCACHE     dcache read; informational, cctrans starts a miss
//  dWEN         in   NCACHE     dcache writeback request
//  daddr        in   NCACHE*AW  dcache word address for the current beat
//  dstore       in   NCACHE*DW  dcache write or supply data
//  dwait        out  NCACHE     dcache stall
//  dload        out  NCACHE*DW  dcache read data
//  cctrans      in   NCACHE     coherent miss request; as a snoop target, snoop-done
//  ccwrite      in   NCACHE     requester: intent to modify; target: holds line Modified
//  ccwait       out  NCACHE     cache is being snooped or is supplying data
//  ccinv        out  NCACHE     invalidate snooped line
//  ccsnoopaddr  out  NCACHE*AW  snoop address
//  ramREN       out  1          RAM read enable
//  ramWEN       out  1          RAM write enable
//  ramaddr      out  AW         RAM address
//  ramstore     out  DW         RAM write data
//  ramload      in   DW         RAM read data
//  ramstate     in   2          0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
// BEHAVIOUR
//  Reset and defaults
//  - Reset (RST=1, async): state=IDLE, rr_ptr=0, beat=0.
//  - Outputs in reset and by default: iwait/dwait all 1; all other outputs 0.
//  State machine: IDLE, WB, SNOOP, C2C, RAMLD, IFETCH
//  - Registers: owner r (log2 NCACHE bits); supplier s; beat counter 0..WPB-1.
//  IDLE arbitration
//  - Priority class: dWEN > cctrans > iREN.
//  - Within a class: round robin, first requester at or after rr_ptr (wrapping).
//  - One cycle: latch r, next state WB / SNOOP / IFETCH.
//  - No requests: stay in IDLE with all outputs at defaults.
//  WB
//  - ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r], dwait[r]=(ramstate!=ACCESS).
//  SNOOP
//  - For every k!=r: ccwait[k]=1, ccsnoopaddr[k]=daddr[r], ccinv[k]=ccwrite[r].
//  - Hold until cctrans[k]=1 for all k!=r.
//  - Then if any responder has ccwrite=1: latch s=lowest such k, go to C2C.
//  - Otherwise go to RAMLD.
//  C2C
//  - dload[r]=dstore[s]; ccwait[s]=1.
//  - Concurrent writeback: ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
//  - dwait[r]=dwait[s]=(ramstate!=ACCESS).
//  RAMLD
//  - ramREN=1, ramaddr=daddr[r], dload[r]=ramload, dwait[r]=(ramstate!=ACCESS).
//  - ccwait stays 1 for all k!=r.
//  IFETCH
//  - ramREN=1, ramaddr=iaddr[r], iload[r]=ramload, iwait[r]=(ramstate!=ACCESS).
//  - Single beat.
//  Beat counting and completion
//  - beat increments on each ramstate==ACCESS cycle in WB/C2C/RAMLD.
//  - ACCESS with beat==WPB-1: beat<=0, rr_ptr<=(r+1) mod NCACHE, state<=IDLE.
//  - IFETCH completes on its first ACCESS cycle, with the same rr_ptr update.
//  Boundary conditions
//  - BUSY/FREE/ERROR: hold state and beat, waits stay asserted.
//  - ERROR never completes a beat.
//  - iREN[r] dropped during IFETCH: next cycle IDLE, no rr_ptr update.
//  - Data transactions are non-abortable; request drops are ignored until the last beat.
//  - Requests arriving mid-transaction wait for IDLE.
//  - The IDLE cycle after completion arbitrates normally.
//  - rr_ptr wraps NCACHE-1 -> 0.
//  Latency
//  - Request to first RAM enable: 1 cycle; snoop adds >=1 cycle.
// TESTING
//  1. NCACHE=4: iREN=4'b1111 held, RAM always ACCESS -> grants 0,1,2,3,0 (one fetch per 2 cycles).
//  2. dWEN[2] and iREN[0] in the same cycle -> WB for cache 2 first: 2 ramWEN beats, then IFETCH 0.
//  3. cctrans[1], ccwrite[1]=1, cache 0 responds cctrans=1/ccwrite=0.
//     -> ccinv[0]=1, ccsnoopaddr[0]=daddr[1]; RAMLD 2 beats; dload[1] = RAM words.
//  4. cctrans[0], responder 3 ccwrite=1 with dstore 0xDEADBEEF, 0xCAFEF00D.
//     -> dload[0] equals those words; RAM written at daddr[3].
//  5. ramstate=BUSY for 5 cycles then ACCESS -> dwait high 5 cycles; beat advances only on ACCESS.
//  6. RST pulsed in RAMLD beat 1 -> outputs default immediately; next request is arbitrated from rr_ptr=0.

Source files
------------

// File: rtl/coherence_bus_arbiter.sv
// rtl/coherence_bus_arbiter.sv - round-robin coherent memory bus controller for NCACHE cache pairs
module coherence_bus_arbiter #(
    parameter int NCACHE = 2,
    parameter int WPB    = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCACHE-1:0]    iREN,
    input  logic [NCACHE*AW-1:0] iaddr,
    output logic [NCACHE-1:0]    iwait,
    output logic [NCACHE*DW-1:0] iload,
    input  logic [NCACHE-1:0]    dREN,
    input  logic [NCACHE-1:0]    dWEN,
    input  logic [NCACHE*AW-1:0] daddr,
    input  logic [NCACHE*DW-1:0] dstore,
    output logic [NCACHE-1:0]    dwait,
    output logic [NCACHE*DW-1:0] dload,
    input  logic [NCACHE-1:0]    cctrans,
    input  logic [NCACHE-1:0]    ccwrite,
    output logic [NCACHE-1:0]    ccwait,
    output logic [NCACHE-1:0]    ccinv,
    output logic [NCACHE*AW-1:0] ccsnoopaddr,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [AW-1:0]        ramaddr,
    output logic [DW-1:0]        ramstore,
    input  logic [DW-1:0]        ramload,
    input  logic [1:0]           ramstate
);

    localparam int RW = $clog2(NCACHE);
    localparam int BW = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, RAMLD, IFETCH} state_t;

    state_t          state, state_nx;
    logic [RW-1:0]   r, r_nx, s, s_nx, rr_ptr, rr_nx, r_plus;
    logic [BW-1:0]   beat, beat_nx;
    logic [NCACHE-1:0] r_mask;
    logic            access, last_beat, all_done;
    logic [RW:0]     d_pick, c_pick, i_pick, s_pick;
    logic            unused_dren;

    // First requester at or after ptr, wrapping; MSB flags that one was found.
    function automatic logic [RW:0] rr_pick(input logic [NCACHE-1:0] req, input logic [RW-1:0] ptr);
        logic [RW:0] res;
        int          idx;
        res = '0;
        for (int i = NCACHE - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NCACHE;
            if (req[idx]) res = {1'b1, RW'(idx)};
        end
        return res;
    endfunction

    // Lowest-numbered requester; MSB flags that one was found.
    function automatic logic [RW:0] low_pick(input logic [NCACHE-1:0] req);
        logic [RW:0] res;
        res = '0;
        for (int k = NCACHE - 1; k >= 0; k--) begin
            if (req[k]) res = {1'b1, RW'(k)};
        end
        return res;
    endfunction

    // dREN is informational only; a miss is started by cctrans.
    assign unused_dren = ^dREN;

    assign access    = (ramstate == RAM_ACCESS);
    assign last_beat = (beat == BW'(WPB - 1));
    assign r_mask    = NCACHE'(1) << r;
    assign all_done  = &(cctrans | r_mask);
    assign r_plus    = (r == RW'(NCACHE - 1)) ? '0 : r + 1'b1;
    assign d_pick    = rr_pick(dWEN, rr_ptr);
    assign c_pick    = rr_pick(cctrans, rr_ptr);
    assign i_pick    = rr_pick(iREN, rr_ptr);
    assign s_pick    = low_pick(ccwrite & ~r_mask);

    // State, owner, supplier, beat and round-robin pointer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            r      <= '0;
            s      <= '0;
            rr_ptr <= '0;
            beat   <= '0;
        end else begin
            state  <= state_nx;
            r      <= r_nx;
            s      <= s_nx;
            rr_ptr <= rr_nx;
            beat   <= beat_nx;
        end
    end

    // Next-state and bus outputs; waits default high, everything else low.
    always_comb begin
        state_nx    = state;
        r_nx        = r;
        s_nx        = s;
        rr_nx       = rr_ptr;
        beat_nx     = beat;
        iwait       = '1;
        iload       = '0;
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            IDLE: begin
                if (d_pick[RW]) begin
                    r_nx     = d_pick[RW-1:0];
                    state_nx = WB;
                end else if (c_pick[RW]) begin
                    r_nx     = c_pick[RW-1:0];
                    state_nx = SNOOP;
                end else if (i_pick[RW]) begin
                    r_nx     = i_pick[RW-1:0];
                    state_nx = IFETCH;
                end
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[r*AW +: AW];
                ramstore = dstore[r*DW +: DW];
                dwait[r] = !access;
            end
            SNOOP: begin
                for (int k = 0; k < NCACHE; k++) begin
                    if (k != int'(r)) begin
                        ccwait[k]                  = 1'b1;
                        ccsnoopaddr[k*AW +: AW]    = daddr[r*AW +: AW];
                        ccinv[k]                   = ccwrite[r];
                    end
                end
                if (all_done) begin
                    if (s_pick[RW]) begin
                        s_nx     = s_pick[RW-1:0];
                        state_nx = C2C;
                    end else begin
                        state_nx = RAMLD;
                    end
                end
            end
            C2C: begin
                dload[r*DW +: DW] = dstore[s*DW +: DW];
                ccwait[s]         = 1'b1;
                ramWEN            = 1'b1;
                ramaddr           = daddr[s*AW +: AW];
                ramstore          = dstore[s*DW +: DW];
                dwait[r]          = !access;
                dwait[s]          = !access;
            end
            RAMLD: begin
                ramREN            = 1'b1;
                ramaddr           = daddr[r*AW +: AW];
                dload[r*DW +: DW] = ramload;
                dwait[r]          = !access;
                ccwait            = ~r_mask;
            end
            IFETCH: begin
                ramREN            = 1'b1;
                ramaddr           = iaddr[r*AW +: AW];
                iload[r*DW +: DW] = ramload;
                iwait[r]          = !access;
                if (!iREN[r]) begin
                    state_nx = IDLE;
                end else if (access) begin
                    rr_nx    = r_plus;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Multi-beat data transfers advance only on ACCESS and finish on the last beat.
        if ((state == WB || state == C2C || state == RAMLD) && access) begin
            if (last_beat) begin
                beat_nx  = '0;
                rr_nx    = r_plus;
                state_nx = IDLE;
            end else begin
                beat_nx = beat + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// tb/tb_coherence_bus_arbiter.sv - directed and randomized checks of coherence_bus_arbiter
module tb_coherence_bus_arbiter;
    localparam int N  = 4;
    localparam int WP = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   iren, iwait, dren, dwen, dwait, cctrans, ccwrite, ccwait, ccinv;
    logic [N*32-1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
    logic           ramren, ramwen;
    logic [31:0]    ramaddr, ramstore, ramload;
    logic [1:0]     ramstate;

    int checks = 0;
    int errors = 0;
    int m_rr   = 0;

    coherence_bus_arbiter #(.NCACHE(N), .WPB(WP), .AW(32), .DW(32)) dut (
        .CLK(clk), .RST(rst),
        .iREN(iren), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dren), .dWEN(dwen), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramren), .ramWEN(ramwen), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fld(input logic [127:0] bus, input int k);
        return bus[k*32 +: 32];
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [3:0] low(input int w);
        return 4'hF & ~(4'd1 << w);
    endfunction

    function automatic logic [127:0] slot(input logic [31:0] v, input int w);
        logic [127:0] t;
        t = {96'd0, v};
        return t << (w * 32);
    endfunction

    task automatic chk_idle(input string tag);
        chk(tag, {ramren, ramwen, iwait, dwait, ccwait}, {2'b00, 4'hF, 4'hF, 4'h0});
    endtask

    initial begin
        logic [3:0] dv, iv;
        int w, kind, acc, cyc;
        rst = 1'b1;
        iren = '0; dren = '0; dwen = '0; cctrans = '0; ccwrite = '0;
        ramstate = 2'd0; ramload = '0;
        for (int k = 0; k < N; k++) begin
            iaddr[k*32 +: 32]  = 32'h1000_0000 + k * 32'h100;
            daddr[k*32 +: 32]  = 32'h2000_0000 + k * 32'h100;
            dstore[k*32 +: 32] = 32'h5000_0000 + k;
        end
        repeat (2) @(negedge clk);
        #1 chk_idle("reset_defaults");
        chk("reset_dload", {dload, iload}, '0);
        @(negedge clk);
        rst = 1'b0;

        // 1: all icaches requesting, RAM always ready
        iren = 4'hF; ramstate = 2'd2;
        for (int g = 0; g < 5; g++) begin
            #1 chk_idle("t1_idle");
            @(negedge clk);
            w = pick(iren, m_rr);
            ramload = 32'hA000_0000 + g;
            #1 chk("t1_grant_iwait", iwait, low(w));
            chk("t1_addr", {ramren, ramaddr}, {1'b1, fld(iaddr, w)});
            chk("t1_iload", iload, slot(ramload, w));
            m_rr = (w + 1) % N;
            @(negedge clk);
        end
        iren = '0;

        // 2: writeback beats priority over an instruction fetch
        dwen = 4'b0100; iren = 4'b0001;
        #1 chk_idle("t2_idle");
        for (int b = 0; b < WP; b++) begin
            @(negedge clk);
            if (b == WP - 1) dwen = '0;
            daddr[2*32 +: 32] = 32'h2000_0200 + b;
            dstore[2*32 +: 32] = 32'h7700_0000 + b;
            #1 chk("t2_wb", {ramwen, ramren, ramaddr, ramstore, dwait, iwait},
                   {1'b1, 1'b0, 32'h2000_0200 + b, 32'h7700_0000 + b, 4'b1011, 4'hF});
        end
        @(negedge clk);
        m_rr = 3;
        #1 chk_idle("t2_idle_after_wb");
        @(negedge clk);
        #1 chk("t2_ifetch", {iwait, ramren, ramaddr}, {4'b1110, 1'b1, fld(iaddr, 0)});
        @(negedge clk);
        m_rr = 1;
        iren = '0;

        // 3: read-for-ownership miss served from RAM
        cctrans = 4'b0010; ccwrite = 4'b0010;
        #1 chk_idle("t3_idle");
        @(negedge clk);
        #1 chk("t3_snoop", {ccwait, ccinv, dwait, ramren}, {4'b1101, 4'b1101, 4'hF, 1'b0});
        chk("t3_snoopaddr", fld(ccsnoopaddr, 0), fld(daddr, 1));
        cctrans = 4'b0011;
        @(negedge clk);
        #1 chk("t3_snoop_hold", {ccwait, ramren, ramwen}, {4'b1101, 1'b0, 1'b0});
        cctrans = 4'hF;
        for (int b = 0; b < WP; b++) begin
            @(negedge clk);
            cctrans = '0; ccwrite = '0;
            daddr[1*32 +: 32] = 32'h2000_0100 + b;
            ramload = 32'h1234_5600 + b;
            #1 chk("t3_ramld", {ramren, ramwen, ramaddr, dwait, ccwait},
                   {1'b1, 1'b0, 32'h2000_0100 + b, 4'b1101, 4'b1101});
            chk("t3_dload", dload, slot(32'h1234_5600 + b, 1));
        end
        @(negedge clk);
        m_rr = 2;
        #1 chk_idle("t3_idle_after");

        // 4: dirty line supplied by cache 3 with concurrent writeback
        cctrans = 4'b0001; ccwrite = 4'b0000;
        @(negedge clk);
        #1 chk("t4_snoop", {ccwait, ccinv}, {4'b1110, 4'b0000});
        chk("t4_snoopaddr", {fld(ccsnoopaddr, 3), fld(ccsnoopaddr, 1)}, {fld(daddr, 0), fld(daddr, 0)});
        cctrans = 4'hF; ccwrite = 4'b1000;
        for (int b = 0; b < WP; b++) begin
            @(negedge clk);
            cctrans = '0; ccwrite = '0;
            dstore[3*32 +: 32] = (b == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D;
            daddr[3*32 +: 32] = 32'h2000_0300 + b;
            #1 chk("t4_c2c", {ramwen, ramren, ramaddr, ramstore, dwait, ccwait},
                   {1'b1, 1'b0, 32'h2000_0300 + b, (b == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D,
                    4'b0110, 4'b1000});
            chk("t4_dload", dload, slot((b == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D, 0));
        end
        @(negedge clk);
        m_rr = 1;
        #1 chk_idle("t4_idle_after");

        // 5: RAM busy/error stalls hold the beat
        dwen = 4'b0010; ramstate = 2'd1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ramstate = (i == 2) ? 2'd3 : 2'd1;
            #1 chk("t5_busy", {ramwen, dwait}, {1'b1, 4'hF});
            @(negedge clk);
        end
        ramstate = 2'd2;
        #1 chk("t5_access0", {ramwen, dwait}, {1'b1, 4'b1101});
        @(negedge clk);
        ramstate = 2'd1; dwen = '0;
        #1 chk("t5_still_wb", {ramwen, dwait}, {1'b1, 4'hF});
        @(negedge clk);
        ramstate = 2'd2;
        #1 chk("t5_access1", {ramwen, dwait}, {1'b1, 4'b1101});
        @(negedge clk);
        m_rr = 2;
        #1 chk_idle("t5_idle_after");

        // 6: reset in RAMLD beat 1 restarts arbitration from pointer 0
        cctrans = 4'b0100;
        @(negedge clk);
        cctrans = 4'hF;
        #1 chk("t6_snoop", ccwait, 4'b1011);
        @(negedge clk);
        cctrans = '0;
        #1 chk("t6_ramld0", {ramren, ccwait}, {1'b1, 4'b1011});
        @(negedge clk);
        ramstate = 2'd1;
        #1 chk("t6_ramld1", ramren, 1'b1);
        rst = 1'b1;
        #1 chk_idle("t6_reset_outputs");
        @(negedge clk);
        rst = 1'b0; m_rr = 0;
        iren = 4'hF; ramstate = 2'd2;
        @(negedge clk);
        #1 chk("t6_grant_after_reset", iwait, low(pick(4'hF, m_rr)));
        @(negedge clk);
        m_rr = 1; iren = '0;

        // 7: fetch abandoned by its requester leaves the pointer alone
        iren = 4'b0010; ramstate = 2'd1;
        @(negedge clk);
        #1 chk("t7_ifetch", {ramren, iwait}, {1'b1, 4'hF});
        iren = '0;
        @(negedge clk);
        #1 chk_idle("t7_abandon_idle");
        iren = 4'hF; ramstate = 2'd2;
        @(negedge clk);
        #1 chk("t7_rr_kept", iwait, low(pick(4'hF, m_rr)));
        m_rr = (pick(4'hF, m_rr) + 1) % N;
        @(negedge clk);
        iren = '0;

        // Randomized writeback / fetch mixes with random RAM handshake
        for (int rnd = 0; rnd < 40; rnd++) begin
            dv = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
            iv = 4'($urandom);
            dwen = dv; iren = iv;
            for (int k = 0; k < N; k++) begin
                iaddr[k*32 +: 32]  = $urandom;
                daddr[k*32 +: 32]  = $urandom;
                dstore[k*32 +: 32] = $urandom;
            end
            #1 chk_idle("rnd_idle");
            kind = (dv != 0) ? 1 : ((iv != 0) ? 2 : 0);
            w = (kind == 1) ? pick(dv, m_rr) : pick(iv, m_rr);
            @(negedge clk);
            if (kind != 0) begin
                acc = 0; cyc = 0;
                while (acc < ((kind == 1) ? WP : 1) && cyc < 100) begin
                    ramstate = ($urandom % 2 == 1) ? 2'd2 : 2'($urandom);
                    ramload = $urandom;
                    #1;
                    if (kind == 1)
                        chk("rnd_wb", {ramwen, ramren, ramaddr, ramstore, iwait, dwait},
                            {1'b1, 1'b0, fld(daddr, w), fld(dstore, w), 4'hF,
                             (ramstate == 2'd2) ? low(w) : 4'hF});
                    else begin
                        chk("rnd_if", {ramren, ramwen, ramaddr, dwait, iwait},
                            {1'b1, 1'b0, fld(iaddr, w), 4'hF,
                             (ramstate == 2'd2) ? low(w) : 4'hF});
                        chk("rnd_iload", iload, slot(ramload, w));
                    end
                    if (ramstate == 2'd2) acc++;
                    cyc++;
                    @(negedge clk);
                end
                chk("rnd_timeout", {31'd0, cyc < 100}, 1);
                m_rr = (w + 1) % N;
            end
        end
        dwen = '0; iren = '0;
        #1 chk_idle("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
